// File: rtl/alu_wide_seq_pkg.sv
// Shared definitions for the wide add/subtract sequencer and the 32-bit ALU:
// opcode constants, slice width, sequencer state encoding and opcode helpers.
package alu_pkg;

    localparam int SLICE_W = 32;

    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_U_ADD = 4'b1000;
    localparam logic [3:0] ALU_U_SUB = 4'b1001;
    localparam logic [3:0] ALU_S_ADD = 4'b1100;
    localparam logic [3:0] ALU_S_SUB = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_FIX,
        ST_DONE
    } seq_state_e;

    // Only the four add/subtract opcodes are meaningful to the wide sequencer.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {ALU_U_ADD, ALU_U_SUB, ALU_S_ADD, ALU_S_SUB};
    endfunction

    // Every slice pass is unsigned; signedness only matters for the final flags.
    function automatic logic [3:0] slice_op(input logic [3:0] op);
        return op[0] ? ALU_U_SUB : ALU_U_ADD;
    endfunction

    // Two's-complement overflow from the sign bits of a, b and the result.
    function automatic logic signed_ovf(input logic is_sub, input logic a_s,
                                        input logic b_s, input logic r_s);
        return is_sub ? ((a_s != b_s) && (r_s != a_s))
                      : ((a_s == b_s) && (r_s != a_s));
    endfunction

endpackage

// File: rtl/alu_wide_seq_if.sv
// Request/response bus of the wide sequencer. The master issues 64-bit
// add/subtract requests and consumes responses; the slave is the sequencer.
interface alu_wide_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow,
               rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow,
               rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_wide_seq_alu.sv
// The existing 32-bit ALU slice. Purely combinational. carry_out is the carry
// for adds and the borrow (b > a) for subtracts; unknown opcodes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]         op,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic [SLICE_W-1:0] result,
    output logic               carry_out,
    output logic               overflow
);

    logic [SLICE_W:0] sum;

    // Add or subtract with one extra bit to expose carry/borrow.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sum      = '0;
        overflow = 1'b0;
        case (op)
            ALU_U_ADD, ALU_S_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                overflow = signed_ovf(1'b0, a[SLICE_W-1], b[SLICE_W-1], sum[SLICE_W-1]);
            end
            ALU_U_SUB, ALU_S_SUB: begin
                sum      = {1'b0, a} - {1'b0, b};
                overflow = signed_ovf(1'b1, a[SLICE_W-1], b[SLICE_W-1], sum[SLICE_W-1]);
            end
            default: sum = '0;
        endcase
        result    = sum[SLICE_W-1:0];
        carry_out = sum[SLICE_W];
    end

endmodule

// File: rtl/alu_wide_seq.sv
// 64-bit add/subtract sequencer on top of the 32-bit ALU. Each request runs a
// low pass, a high pass and, when the low half carried/borrowed, a fix pass
// that propagates it into the high half. Flags are computed locally.
// Optional feature: define ALU_WIDE_PERF_CNT_EN to add perf_ops / perf_fix.
module alu_wide_seq
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu_wide_seq_if.slave      bus
`ifdef ALU_WIDE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_fix
`endif
);

    seq_state_e         state;
    logic [3:0]         op_q;
    logic [63:0]        a_q;
    logic [63:0]        b_q;
    logic [SLICE_W-1:0] lo_q;
    logic [SLICE_W-1:0] hi_q;
    logic               c0_q;
    logic               c1_q;

    logic [3:0]         alu_op;
    logic [SLICE_W-1:0] alu_a;
    logic [SLICE_W-1:0] alu_b;
    logic [SLICE_W-1:0] alu_result;
    logic               alu_carry;
    logic               alu_ovf_unused;

    logic               fin_now;
    logic [63:0]        fin_result;
    logic               fin_cout;
    logic               fin_ovf;

    alu u_alu (
        .op        (alu_op),
        .a         (alu_a),
        .b         (alu_b),
        .result    (alu_result),
        .carry_out (alu_carry),
        .overflow  (alu_ovf_unused)
    );

    // Drive the ALU for the current pass; idle ALU inputs are held at zero.
    always_comb begin
        alu_op = ALU_NOP;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            ST_LO: begin
                if (is_legal_op(op_q)) begin
                    alu_op = slice_op(op_q);
                    alu_a  = a_q[SLICE_W-1:0];
                    alu_b  = b_q[SLICE_W-1:0];
                end
            end
            ST_HI: begin
                alu_op = slice_op(op_q);
                alu_a  = a_q[63:SLICE_W];
                alu_b  = b_q[63:SLICE_W];
            end
            ST_FIX: begin
                alu_op = slice_op(op_q);
                alu_a  = hi_q;
                alu_b  = 32'h1;
            end
            default: ;
        endcase
    end

    // Final result and flags, valid in the pass that completes the request.
    always_comb begin
        fin_now    = ((state == ST_HI) && !c0_q) || (state == ST_FIX);
        fin_result = {alu_result, lo_q};
        fin_cout   = (state == ST_FIX) ? (c1_q | alu_carry) : alu_carry;
        fin_ovf    = signed_ovf(op_q[0], a_q[63], b_q[63], alu_result[SLICE_W-1]);
    end

    // Sequencer FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand/partial registers are reset too; they are few and it keeps the response deterministic.
            state            <= ST_IDLE;
            op_q             <= ALU_NOP;
            a_q              <= '0;
            b_q              <= '0;
            lo_q             <= '0;
            hi_q             <= '0;
            c0_q             <= 1'b0;
            c1_q             <= 1'b0;
            bus.req_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_carry    <= 1'b0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_zero     <= 1'b0;
            bus.rsp_err      <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= bus.req_op;
                        a_q           <= bus.req_a;
                        b_q           <= bus.req_b;
                        bus.req_ready <= 1'b0;
                        state         <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (!is_legal_op(op_q)) begin
                        bus.rsp_result   <= '0;
                        bus.rsp_zero     <= 1'b1;
                        bus.rsp_err      <= 1'b1;
                        bus.rsp_carry    <= 1'b0;
                        bus.rsp_overflow <= 1'b0;
                        bus.rsp_valid    <= 1'b1;
                        state            <= ST_DONE;
                    end else begin
                        lo_q  <= alu_result;
                        c0_q  <= alu_carry;
                        state <= ST_HI;
                    end
                end
                ST_HI: begin
                    hi_q  <= alu_result;
                    c1_q  <= alu_carry;
                    state <= c0_q ? ST_FIX : ST_DONE;
                end
                ST_FIX: begin
                    hi_q  <= alu_result;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (fin_now) begin
                bus.rsp_result   <= fin_result;
                bus.rsp_zero     <= (fin_result == 64'd0);
                bus.rsp_carry    <= !op_q[2] && fin_cout;
                bus.rsp_overflow <= op_q[2] && fin_ovf;
                bus.rsp_err      <= 1'b0;
                bus.rsp_valid    <= 1'b1;
            end
        end
    end

`ifdef ALU_WIDE_PERF_CNT_EN
    // Completed-response and fix-pass counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops <= '0;
            perf_fix <= '0;
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) perf_ops <= perf_ops + 32'd1;
            if (state == ST_FIX)                perf_fix <= perf_fix + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed testbench for alu_wide_seq: hand-computed vectors, latency,
// back-pressure hold, mid-operation reset and illegal opcode handling.
module tb_alu_wide_seq;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_wide_seq_if bus ();

`ifdef ALU_WIDE_PERF_CNT_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_fix;
`endif

    alu_wide_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_WIDE_PERF_CNT_EN
        ,
        .perf_ops (perf_ops),
        .perf_fix (perf_fix)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns after the accept edge (E0).
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Count edges after E0 until rsp_valid is seen, bounded.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat = 0;
        bit got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) got = 1;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_rsp(input string tag, input logic [63:0] res, input logic c,
                             input logic v, input logic z, input logic e);
        check({tag, "_res"},  bus.rsp_result, res);
        check({tag, "_carry"}, 64'(bus.rsp_carry), 64'(c));
        check({tag, "_ovf"},  64'(bus.rsp_overflow), 64'(v));
        check({tag, "_zero"}, 64'(bus.rsp_zero), 64'(z));
        check({tag, "_err"},  64'(bus.rsp_err), 64'(e));
    endtask

    task automatic handshake(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_vld_drop"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rdy_back"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input int lat, input logic [63:0] res,
                       input logic c, input logic v, input logic z, input logic e);
        issue(op, a, b);
        check({tag, "_busy"}, 64'(bus.req_ready), 64'd0);
        wait_rsp(tag, lat);
        check_rsp(tag, res, c, v, z, e);
        handshake(tag);
    endtask

    initial begin
        int seen;
`ifdef ALU_WIDE_PERF_CNT_EN
        logic [31:0] ops0, fix0;
`endif
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = ALU_NOP;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_rsp("rst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Carry out of the low half: fix pass taken.
        run("uadd_fix", ALU_U_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1, 3,
            64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run("uadd_wrap", ALU_U_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3,
            64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        run("usub_wrap", ALU_U_SUB, 64'd0, 64'd1, 3,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run("usub_borrow", ALU_U_SUB, 64'h1_0000_0000, 64'd1, 3,
            64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run("uadd_small", ALU_U_ADD, 64'd3, 64'd4, 2,
            64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        run("uadd_hi_carry", ALU_U_ADD, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 2,
            64'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        run("sadd_ovf", ALU_S_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3,
            64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run("ssub_ovf", ALU_S_SUB, 64'h8000_0000_0000_0000, 64'd1, 3,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run("ssub_neg", ALU_S_SUB, 64'd5, 64'd7, 3,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);

        // rsp_ready already high when the response appears.
        bus.rsp_ready = 1'b1;
        issue(ALU_U_SUB, 64'd9, 64'd2);
        wait_rsp("early", 2);
        check("early_res", bus.rsp_result, 64'd7);
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("early_vld_drop", 64'(bus.rsp_valid), 64'd0);
        check("early_rdy_back", 64'(bus.req_ready), 64'd1);

        // Back-pressure: response held, new requests ignored.
        issue(ALU_U_ADD, 64'd3, 64'd4);
        wait_rsp("hold", 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.req_valid = 1'b1;
                bus.req_op    = ALU_U_SUB;
                bus.req_a     = 64'd100;
                bus.req_b     = 64'd1;
            end
            @(posedge clk);
            @(negedge clk);
            check("hold_res", bus.rsp_result, 64'd7);
            check("hold_vld", 64'(bus.rsp_valid), 64'd1);
            check("hold_rdy", 64'(bus.req_ready), 64'd0);
        end
        check_rsp("hold_flags", 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.req_valid = 1'b0;
        handshake("hold");
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("hold_no_extra", 64'(seen), 64'd0);

        // Reset during the HI pass drops the request.
        issue(ALU_U_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_vld", 64'(bus.rsp_valid), 64'd0);
        check("midrst_rdy", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("midrst_no_rsp", 64'(seen), 64'd0);
        check("midrst_idle_rdy", 64'(bus.req_ready), 64'd1);

        // Illegal opcode.
`ifdef ALU_WIDE_PERF_CNT_EN
        ops0 = perf_ops;
        fix0 = perf_fix;
`endif
        run("illegal", ALU_NOP, 64'd12, 64'd34, 1,
            64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef ALU_WIDE_PERF_CNT_EN
        check("perf_ops_inc", 64'(perf_ops), 64'(ops0 + 32'd1));
        check("perf_fix_same", 64'(perf_fix), 64'(fix0));
`endif
        // Legal op after an error clears err.
        run("after_err", ALU_S_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
